// File: rtl/alu_issue.sv
// alu_issue: issue and writeback stage wrapped around an external combinational alu32.
// Decodes instruction words, reads a 32x32 register file, holds one instruction in an
// execute register that drives the ALU, and streams results out over valid/ready.
// Optional feature macro: ALU_ISSUE_FWD_EN (bypass in-flight result instead of stalling).
module alu_issue #(
  parameter logic [31:0] RESET_REG = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_ovf,
  output logic        res_illegal,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef struct packed {
    logic        legal;
    logic [4:0]  dst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  opcode;
    logic [5:0]  funct;
  } dec_t;

  // Instruction fields
  logic [5:0]  f_op;
  logic [5:0]  f_funct;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [15:0] f_imm;

  assign f_op    = in_instr[31:26];
  assign f_rs    = in_instr[25:21];
  assign f_rt    = in_instr[20:16];
  assign f_rd    = in_instr[15:11];
  assign f_funct = in_instr[5:0];
  assign f_imm   = in_instr[15:0];

  // Register file; entry 0 is never written and reads of r0 are forced to 0.
  logic [31:0] rf [32];

  // Execute register
  logic        ex_valid;
  logic        ex_illegal;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;

  logic [31:0] rf_rs;
  logic [31:0] rf_rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hit_rs;
  logic        hit_rt;
  logic        uses_rs;
  logic        uses_rt;
  logic        hazard;
  logic        accept;
  logic        wb_en;
  dec_t        dec;

  assign rf_rs = (f_rs == 5'd0) ? 32'h0 : rf[f_rs];
  assign rf_rt = (f_rt == 5'd0) ? 32'h0 : rf[f_rt];

  // The in-flight instruction will write this register when it retires.
  assign hit_rs = ex_valid && !ex_illegal && (ex_rd != 5'd0) && (ex_rd == f_rs);
  assign hit_rt = ex_valid && !ex_illegal && (ex_rd != 5'd0) && (ex_rt_match());

  function automatic logic ex_rt_match();
    return ex_rd == f_rt;
  endfunction

`ifdef ALU_ISSUE_FWD_EN
  // Take a dependent operand straight from the ALU so no bubble is needed.
  assign rs_val = hit_rs ? alu_result : rf_rs;
  assign rt_val = hit_rt ? alu_result : rf_rt;
  assign hazard = 1'b0;
  logic unused_uses;
  assign unused_uses = uses_rs ^ uses_rt;
`else
  // Hold off a dependent instruction until its producer has written back.
  assign rs_val = rf_rs;
  assign rt_val = rf_rt;
  assign hazard = in_valid && ((uses_rs && hit_rs) || (uses_rt && hit_rt));
`endif

  // Decode the offered instruction into ALU operands and controls.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    unique case (f_op)
      6'b000000: begin
        case (f_funct)
          6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
          6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b010100,
          6'b011001, 6'b011010, 6'b011011, 6'b101000: dec.legal = 1'b1;
          default:                                     dec.legal = 1'b0;
        endcase
        dec.dst   = f_rd;
        dec.op1   = rs_val;
        dec.op2   = rt_val;
        dec.funct = f_funct;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
      end
      6'b001000, 6'b001001: begin
        dec.legal = 1'b1;
        dec.dst   = f_rt;
        dec.op1   = rs_val;
        dec.op2   = {{16{f_imm[15]}}, f_imm};
        uses_rs   = 1'b1;
      end
      6'b010000, 6'b010001, 6'b010010, 6'b011000, 6'b011001, 6'b011010: begin
        dec.legal = 1'b1;
        dec.dst   = f_rt;
        dec.op1   = rs_val;
        dec.op2   = {16'h0, f_imm};
        uses_rs   = 1'b1;
      end
      6'b110000: begin
        dec.legal = 1'b1;
        dec.dst   = f_rt;
        dec.op1   = 32'h0;
        dec.op2   = {16'h0, f_imm};
      end
      default: dec.legal = 1'b0;
    endcase
    if (dec.legal) begin
      dec.opcode = f_op;
    end else begin
      // Illegal words present all-zero ALU controls and never create a dependency.
      dec.op1   = 32'h0;
      dec.op2   = 32'h0;
      dec.funct = 6'h0;
      uses_rs   = 1'b0;
      uses_rt   = 1'b0;
    end
  end

  assign in_ready = (!ex_valid || res_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign wb_en    = ex_valid && res_ready && !ex_illegal && (ex_rd != 5'd0);

  // Execute register: load on acceptance, empty when the result drains.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_rd      <= 5'd0;
      ex_rs1     <= 32'h0;
      ex_rs2     <= 32'h0;
      ex_opcode  <= 6'h0;
      ex_funct   <= 6'h0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_illegal <= !dec.legal;
      ex_rd      <= dec.dst;
      ex_rs1     <= dec.op1;
      ex_rs2     <= dec.op2;
      ex_opcode  <= dec.opcode;
      ex_funct   <= dec.funct;
    end else if (res_ready) begin
      ex_valid   <= 1'b0;
    end
  end

  // Register file writeback on result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the register file has a defined reset value, so every entry is reset here;
    // a plain storage array without that need would be left out of the reset branch.
    if (!rst_n) begin
      rf[0] <= 32'h0;
      for (int i = 1; i < 32; i++) rf[i] <= RESET_REG;
    end else if (wb_en) begin
      rf[ex_rd] <= alu_result;
    end
  end

  assign alu_rs1     = ex_rs1;
  assign alu_rs2     = ex_rs2;
  assign alu_opcode  = ex_opcode;
  assign alu_funct   = ex_funct;
  assign res_valid   = ex_valid;
  assign res_rd      = ex_rd;
  assign res_illegal = ex_valid && ex_illegal;
  assign res_data    = (ex_valid && !ex_illegal) ? alu_result : 32'h0;
  assign res_ovf     = ex_valid && !ex_illegal && alu_ovf;
  assign dbg_rdata   = (dbg_raddr == 5'd0) ? 32'h0 : rf[dbg_raddr];

  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue with a behavioural alu32 stand-in.
// Directed table vectors, multi-cycle corner sequences, then a randomized stream checked
// against an in-order architectural model.
module tb_alu_issue;

  localparam logic [31:0] TB_RESET = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_ovf;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_ovf;
  logic        res_illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue #(.RESET_REG(TB_RESET)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .res_ovf(res_ovf), .res_illegal(res_illegal),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {ovf, result}.
  function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic        v;
    s = 32'h0;
    v = 1'b0;
    if (op == 6'b000000) begin
      case (fn)
        6'b001000: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
        6'b001001: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
        6'b001010: s = a & b;
        6'b001011: s = a | b;
        6'b001100: s = a ^ b;
        6'b001101: s = ~(a | b);
        6'b010000: s = a << b[4:0];
        6'b010001: s = a >> b[4:0];
        6'b010010: s = $unsigned($signed(a) >>> b[4:0]);
        6'b010011: s = {31'h0, $signed(a) < $signed(b)};
        6'b010100: s = {31'h0, a < b};
        6'b011001: s = a * b;
        6'b011010: s = (a > b) ? a : b;
        6'b011011: s = (a < b) ? a : b;
        6'b101000: s = a;
        default:   s = 32'h0;
      endcase
    end else begin
      case (op)
        6'b001000: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
        6'b001001: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
        6'b010000: s = a & b;
        6'b010001: s = a | b;
        6'b010010: s = a ^ b;
        6'b011000: s = {31'h0, $signed(a) < $signed(b)};
        6'b011001: s = {31'h0, a < b};
        6'b011010: s = a >> b[4:0];
        6'b110000: s = b << 16;
        default:   s = 32'h0;
      endcase
    end
    return {v, s};
  endfunction

  assign {alu_ovf, alu_result} = alu_fn(alu_opcode, alu_funct, alu_rs1, alu_rs2);
  assign alu_zero = (alu_result == 32'h0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (in-order architectural execution) ----------------
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic [31:0] mrf [32];
  exp_t        exp_q [$];

  logic [5:0] legal_functs [15] = '{6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o15, 6'o20, 6'o21,
                                    6'o22, 6'o23, 6'o24, 6'o31, 6'o32, 6'o33, 6'o50};
  logic [5:0] gen_ops [14] = '{6'o00, 6'o00, 6'o00, 6'o10, 6'o11, 6'o20, 6'o21, 6'o22,
                               6'o30, 6'o31, 6'o32, 6'o60, 6'o77, 6'o05};

  task automatic model_issue(input logic [31:0] instr, output exp_t e);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        legal;
    logic [32:0] r;
    op    = instr[31:26];
    fn    = 6'h0;
    a     = mrf[instr[25:21]];
    dst   = instr[20:16];
    legal = 1'b1;
    if (op == 6'o00) begin
      legal = 1'b0;
      foreach (legal_functs[i]) if (legal_functs[i] == instr[5:0]) legal = 1'b1;
      fn  = instr[5:0];
      b   = mrf[instr[20:16]];
      dst = instr[15:11];
    end else if (op == 6'o10 || op == 6'o11) begin
      b = {{16{instr[15]}}, instr[15:0]};
    end else if (op inside {6'o20, 6'o21, 6'o22, 6'o30, 6'o31, 6'o32}) begin
      b = {16'h0, instr[15:0]};
    end else if (op == 6'o60) begin
      a = 32'h0;
      b = {16'h0, instr[15:0]};
    end else begin
      legal = 1'b0;
      b     = 32'h0;
    end
    r     = alu_fn(op, fn, a, b);
    e.ill = !legal;
    e.rd  = dst;
    e.data = legal ? r[31:0] : 32'h0;
    e.ovf  = legal ? r[32] : 1'b0;
    if (legal && dst != 5'd0) mrf[dst] = r[31:0];
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    op = gen_ops[$urandom_range(0, 13)];
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (op == 6'o00) begin
      fn = ($urandom_range(0, 7) == 0) ? 6'o76 : legal_functs[$urandom_range(0, 14)];
      return {op, rs, rt, rd, 5'($urandom), fn};
    end
    return {op, rs, rt, 16'($urandom)};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic        ill;
  } vec_t;

  vec_t vt [9];

  initial begin
    int   stalls;
    int   exp_stalls;
    bit   accepted;
    int   hs_count;
    bit   offered;
    bit   was_stalled;
    logic [31:0] cur_instr;
    logic [31:0] prev_data;
    logic [31:0] prev_rs2;
    exp_t e;
    exp_t got;

    vt[0] = '{32'h20010005, 32'h0, 32'h5,        32'h5,        5'd1, 6'o00, 1'b0}; // ADDI r1,r0,5
    vt[1] = '{32'h2402FFFF, 32'h0, 32'hFFFFFFFF, 32'h1,        5'd2, 6'o00, 1'b0}; // SUBI r2,r0,-1
    vt[2] = '{32'h4003FFFF, 32'h0, 32'h0000FFFF, 32'h0,        5'd3, 6'o00, 1'b0}; // ANDI r3,r0
    vt[3] = '{32'hC004ABCD, 32'h0, 32'h0000ABCD, 32'hABCD0000, 5'd4, 6'o00, 1'b0}; // LUI r4
    vt[4] = '{32'h442500F0, 32'h5, 32'h000000F0, 32'hF5,       5'd5, 6'o00, 1'b0}; // ORI r5,r1
    vt[5] = '{32'h00223008, 32'h5, 32'h1,        32'h6,        5'd6, 6'o10, 1'b0}; // ADD r6,r1,r2
    vt[6] = '{32'hFC01FFFF, 32'h0, 32'h0,        32'h0,        5'd0, 6'o00, 1'b1}; // opcode 111111
    vt[7] = '{32'h00223800, 32'h0, 32'h0,        32'h0,        5'd0, 6'o00, 1'b1}; // bad funct
    vt[8] = '{32'h00220009, 32'h5, 32'h1,        32'h4,        5'd0, 6'o11, 1'b0}; // SUB r0,r1,r2

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    res_ready = 1'b1;
    dbg_raddr = 5'd1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_res_valid", 32'(res_valid), 32'h0);
    check("reset_res_data", res_data, 32'h0);
    check("reset_alu_rs2", alu_rs2, 32'h0);
    check("reset_alu_opcode", 32'(alu_opcode), 32'h0);
    check("reset_r1", dbg_rdata, TB_RESET);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: one instruction, one check cycle, drained before the next.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      #1 check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'h1);
      check($sformatf("v%0d_alu_rs1", i), alu_rs1, vt[i].rs1);
      check($sformatf("v%0d_alu_rs2", i), alu_rs2, vt[i].rs2);
      check($sformatf("v%0d_alu_funct", i), 32'(alu_funct), 32'(vt[i].fn));
      check($sformatf("v%0d_res_data", i), res_data, vt[i].data);
      check($sformatf("v%0d_illegal", i), 32'(res_illegal), 32'(vt[i].ill));
      if (!vt[i].ill) check($sformatf("v%0d_res_rd", i), 32'(res_rd), 32'(vt[i].rd));
    end
    @(negedge clk);
    begin
      logic [31:0] exp_rf [8] = '{32'h0, 32'h5, 32'h1, 32'h0, 32'hABCD0000, 32'hF5, 32'h6, 32'h0};
      for (int r = 0; r < 8; r++) begin
        dbg_raddr = 5'(r);
        #1 check($sformatf("table_r%0d", r), dbg_rdata, exp_rf[r]);
      end
    end

    // Back-to-back dependency: ADDI r1,r0,5 then ADD r2,r1,r1.
`ifdef ALU_ISSUE_FWD_EN
    exp_stalls = 0;
`else
    exp_stalls = 1;
`endif
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h20010005;
    #1 check("b2b_first_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_instr = 32'h00211008;
    stalls   = 0;
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (in_ready) accepted = 1'b1;
      else stalls++;
    end
    check("b2b_accepted", 32'(accepted), 32'h1);
    check("b2b_stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_res_data", res_data, 32'd10);
    check("b2b_res_rd", 32'(res_rd), 32'd2);
    @(negedge clk);
    dbg_raddr = 5'd2;
    #1 check("b2b_r2", dbg_rdata, 32'd10);

    // Backpressure: result held 3 cycles while the next word waits.
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h20070007;
    hs_count  = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_instr = 32'h20080008;
      #1;
      check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'h0);
      check($sformatf("bp_res_data_%0d", c), res_data, 32'd7);
      check($sformatf("bp_alu_rs2_%0d", c), alu_rs2, 32'd7);
      check($sformatf("bp_res_rd_%0d", c), 32'(res_rd), 32'd7);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    if (res_valid && res_ready) hs_count++;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    if (res_valid && res_ready) hs_count++;
    check("bp_second_data", res_data, 32'd8);
    dbg_raddr = 5'd7;
    #1 check("bp_r7", dbg_rdata, 32'd7);
    @(negedge clk);
    #1;
    if (res_valid && res_ready) hs_count++;
    check("bp_handshakes", 32'(hs_count), 32'd2);
    dbg_raddr = 5'd8;
    #1 check("bp_r8", dbg_rdata, 32'd8);

    // Reset while an instruction is in flight: no writeback, outputs clear at once.
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h20090009;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("rst_inflight_valid", 32'(res_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    dbg_raddr = 5'd9;
    #1 check("rst_r9", dbg_rdata, TB_RESET);

    // Randomized stream against the in-order model.
    mrf[0] = 32'h0;
    for (int r = 1; r < 32; r++) mrf[r] = TB_RESET;
    offered     = 1'b0;
    was_stalled = 1'b0;
    cur_instr   = 32'h0;
    prev_data   = 32'h0;
    prev_rs2    = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc >= 2990) begin
        offered  = 1'b0;
        res_ready = 1'b1;
      end else begin
        if (!offered && $urandom_range(0, 3) != 0) begin
          cur_instr = gen_instr();
          offered   = 1'b1;
        end
        res_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = offered;
      in_instr = cur_instr;
      #1;
      if (was_stalled) begin
        check("rnd_hold_data", res_data, prev_data);
        check("rnd_hold_rs2", alu_rs2, prev_rs2);
      end
      if (res_valid && res_ready) begin
        check("rnd_result_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check("rnd_illegal", 32'(res_illegal), 32'(got.ill));
          check("rnd_data", res_data, got.data);
          check("rnd_ovf", 32'(res_ovf), 32'(got.ovf));
          if (!got.ill) check("rnd_rd", 32'(res_rd), 32'(got.rd));
        end
      end
      if (in_valid && in_ready) begin
        model_issue(in_instr, e);
        exp_q.push_back(e);
        offered = 1'b0;
      end
      was_stalled = res_valid && !res_ready;
      prev_data   = res_data;
      prev_rs2    = alu_rs2;
    end
    check("rnd_queue_drained", 32'(exp_q.size()), 32'h0);
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r);
      #1 check($sformatf("rnd_r%0d", r), dbg_rdata, mrf[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
